shift_add_multiplier: RTL and testbench

SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

---
 rtl/mult_pkg.sv | 27 ++
 rtl/mult_shift_add_step.sv | 30 +++
 rtl/shift_add_multiplier.sv | 152 +++++++++++++++
 tb/tb_shift_add_multiplier.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mult_pkg
//  Description : Shared definitions for the shift-and-add multiplier:
//                FSM state encoding and iteration-counter width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package mult_pkg;

    // Legal operand-width range for the multiplier
    localparam int N_MIN = 4;
    localparam int N_MAX = 32;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // The counter must hold the value N itself, hence N+1 distinct values.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mult_shift_add_step.sv
`default_nettype none
// ============================================================================
//  Module      : mult_shift_add_step
//  Description : One combinational shift-and-add iteration. Adds the shifted
//                multiplicand into the accumulator when the multiplier LSB is
//                set, then shifts multiplicand left and multiplier right.
//  Ports       : acc_i/acc_o       2N-bit accumulator (current / next)
//                mcand_i/mcand_o   2N-bit multiplicand magnitude (cur / next)
//                mplier_i/mplier_o N-bit multiplier magnitude (cur / next)
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_shift_add_step
    import mult_pkg::*;
#(
    parameter int N = 6
) (
    input  logic [2*N-1:0] acc_i,
    input  logic [2*N-1:0] mcand_i,
    input  logic [N-1:0]   mplier_i,
    output logic [2*N-1:0] acc_o,
    output logic [2*N-1:0] mcand_o,
    output logic [N-1:0]   mplier_o
);

    assign acc_o    = mplier_i[0] ? (acc_i + mcand_i) : acc_i;
    assign mcand_o  = mcand_i << 1;
    assign mplier_o = mplier_i >> 1;

endmodule
`default_nettype wire

// File: rtl/shift_add_multiplier.sv
`default_nettype none
// ============================================================================
//  Module      : shift_add_multiplier
//  Description : Sequential N-iteration shift-and-add multiplier with
//                valid/ready handshakes on both sides. Supports unsigned and
//                two's-complement operands by multiplying magnitudes and
//                negating the result when the operand signs differ.
//  Ports       : clk          clock, rising edge
//                rst          asynchronous active-high reset
//                m, q         N-bit multiplicand / multiplier
//                signed_mode  1 = two's-complement operands, 0 = unsigned
//                in_valid     operands valid          (input handshake)
//                in_ready     block can accept        (input handshake)
//                P            2N-bit registered product
//                out_valid    P valid                 (output handshake)
//                out_ready    consumer accepts P      (output handshake)
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_add_multiplier
    import mult_pkg::*;
#(
    parameter int N = 6
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   m,
    input  logic [N-1:0]   q,
    input  logic           signed_mode,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [2*N-1:0] P,
    output logic           out_valid,
    input  logic           out_ready
);

    localparam int CW = cnt_width(N);

    state_t           state_q,  state_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic [2*N-1:0]   acc_q,    acc_d;
    logic [2*N-1:0]   mcand_q,  mcand_d;
    logic [N-1:0]     mplier_q, mplier_d;
    logic             neg_q,    neg_d;
    logic [2*N-1:0]   p_q,      p_d;

    logic [2*N-1:0]   acc_nx;
    logic [2*N-1:0]   mcand_nx;
    logic [N-1:0]     mplier_nx;

    // Operand magnitudes. The multiplicand is widened to 2N bits before
    // negation so -2^(N-1) becomes +2^(N-1) rather than wrapping. For the
    // multiplier, N unsigned bits already hold 2^(N-1).
    logic             m_neg;
    logic             q_neg;
    logic [2*N-1:0]   m_ext;
    logic [2*N-1:0]   m_mag;
    logic [N-1:0]     q_mag;

    assign m_neg = signed_mode & m[N-1];
    assign q_neg = signed_mode & q[N-1];
    assign m_ext = {{N{m_neg}}, m};
    assign m_mag = m_neg ? -m_ext : m_ext;
    assign q_mag = q_neg ? -q : q;

    mult_shift_add_step #(
        .N (N)
    ) u_step (
        .acc_i    (acc_q),
        .mcand_i  (mcand_q),
        .mplier_i (mplier_q),
        .acc_o    (acc_nx),
        .mcand_o  (mcand_nx),
        .mplier_o (mplier_nx)
    );

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
            p_q      <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            neg_q    <= neg_d;
            p_q      <= p_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        neg_d     = neg_q;
        p_d       = p_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    mcand_d  = m_mag;
                    mplier_d = q_mag;
                    neg_d    = m_neg ^ q_neg;
                    cnt_d    = CW'(N);
                    acc_d    = '0;
                    state_d  = CALC;
                end
            end
            CALC: begin
                acc_d    = acc_nx;
                mcand_d  = mcand_nx;
                mplier_d = mplier_nx;
                cnt_d    = cnt_q - CW'(1);
                // Last iteration: publish the step result directly so the
                // product appears on the same edge the counter reaches zero.
                if (cnt_q == CW'(1)) begin
                    p_d     = neg_q ? -acc_nx : acc_nx;
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign P = p_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_add_multiplier.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_add_multiplier
//  Description : Self-checking bench for shift_add_multiplier (N=6). Directed
//                vectors plus randomized back-to-back traffic compared with
//                an arithmetic reference product.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_add_multiplier;

    localparam int N = 6;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   m = '0;
    logic [N-1:0]   q = '0;
    logic           signed_mode = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [2*N-1:0] P;
    logic           out_valid;
    logic           out_ready = 1'b0;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_acc = -100;
    bit prev_hold0 = 1'b0;

    shift_add_multiplier #(
        .N (N)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .m           (m),
        .q           (q),
        .signed_mode (signed_mode),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .P           (P),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference: plain integer product of the interpreted operands.
    function automatic logic [2*N-1:0] ref_prod(input logic [N-1:0] a, input logic [N-1:0] b,
                                                input logic s);
        longint x;
        longint y;
        longint p;
        x = s ? longint'($signed(a)) : longint'(a);
        y = s ? longint'($signed(b)) : longint'(b);
        p = x * y;
        return p[2*N-1:0];
    endfunction

    // Called just after a falling edge with the block in IDLE.
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic s,
                          input logic [2*N-1:0] exp, input int hold, input bit noise,
                          input bit chk_tp);
        int k;
        m           = a;
        q           = b;
        signed_mode = s;
        in_valid    = 1'b1;
        out_ready   = 1'b0;
        check("in_ready_idle", in_ready, 1);
        @(posedge clk);
        k = 0;
        forever begin
            @(negedge clk);
            if (k == 0) begin
                if (chk_tp) check("throughput", cyc - last_acc, N + 2);
                last_acc = cyc;
            end
            if (out_valid === 1'b1) break;
            if (noise) begin
                in_valid    = 1'($urandom);
                m           = N'($urandom);
                q           = N'($urandom);
                signed_mode = 1'($urandom);
            end else begin
                in_valid = 1'b0;
            end
            k++;
            if (k > 3 * N) begin
                check("timeout_latency", k, N);
                return;
            end
        end
        check("latency", k, N);
        check("product", P, exp);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_P", P, exp);
            check("hold_out_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
            if (noise) begin
                in_valid = 1'($urandom);
                m        = N'($urandom);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("release_in_ready", in_ready, 1);
        check("release_out_valid", out_valid, 0);
        out_ready = 1'b0;
        in_valid  = 1'b0;
    endtask

    initial begin
        logic [N-1:0] ra;
        logic [N-1:0] rb;
        logic         rs;
        int           hold;

        // Reset applied before any clock edge: outputs must follow at once.
        #1 rst = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_P", P, 0);
        @(negedge clk);
        rst = 1'b0;

        run_op(6'd63, 6'd63, 1'b0, 12'hF81, 0, 1'b0, 1'b0);
        run_op(6'h20, 6'h20, 1'b1, 12'h400, 0, 1'b0, 1'b1);
        run_op(6'h3F, 6'd5,  1'b1, 12'hFFB, 10, 1'b0, 1'b0);

        // Abort an operation after three CALC iterations.
        m = 6'd21; q = 6'd13; signed_mode = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_P", P, 0);
        check("abort_in_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;

        run_op(6'd7, 6'd9,  1'b0, 12'd63, 0, 1'b0, 1'b0);
        run_op(6'd0, 6'd45, 1'b0, 12'd0,  0, 1'b1, 1'b1);

        for (int i = 0; i < 1000; i++) begin
            ra   = N'($urandom);
            rb   = N'($urandom);
            rs   = 1'($urandom);
            hold = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 4));
            run_op(ra, rb, rs, ref_prod(ra, rb, rs), hold, 1'b1, (i > 0) && prev_hold0);
            prev_hold0 = (hold == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
